// File: rtl/pos_arith_pkg.sv
// rtl/pos_arith_pkg.sv - FSM state encodings and op constants for pos_addsub_seq (ST_NEG only with POS_ADDSUB_SEQ_ABS_EN)
package pos_arith_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

`ifdef POS_ADDSUB_SEQ_ABS_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_NEG  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    // A zero result width means "one bit wider than the left operand".
    function automatic int result_width(input int n_bits_l, input int n_bits);
        return (n_bits == 0) ? n_bits_l + 1 : n_bits;
    endfunction

endpackage

// File: rtl/chunk_addsub.sv
// rtl/chunk_addsub.sv - combinational CHUNK-bit adder/subtractor; cout is carry (add) or borrow (sub)
module chunk_addsub
    import pos_arith_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             op,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] r;

    // Subtraction wraps below zero, so bit CHUNK is set exactly when a < b + cin.
    always_comb begin
        if (op == OP_ADD) begin
            r = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        end else begin
            r = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, cin};
        end
    end

    assign s    = r[CHUNK-1:0];
    assign cout = r[CHUNK];

endmodule

// File: rtl/pos_addsub_seq.sv
// rtl/pos_addsub_seq.sv - slice-serial unsigned add/sub; POS_ADDSUB_SEQ_ABS_EN adds magnitude output with neg flag
module pos_addsub_seq
    import pos_arith_pkg::*;
#(
    parameter int N_BITS_L = 8,
    parameter int N_BITS_R = 8,
    parameter int N_BITS   = 0,
    parameter int CHUNK    = 4,
    localparam int N_BITS_RESULT = result_width(N_BITS_L, N_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op,
    input  logic [N_BITS_L-1:0]      a,
    input  logic [N_BITS_R-1:0]      b,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef POS_ADDSUB_SEQ_ABS_EN
    output logic                     neg,
`endif
    output logic [N_BITS_RESULT-1:0] c
);

    localparam int NCH  = (N_BITS_RESULT + CHUNK - 1) / CHUNK;
    localparam int NPAD = NCH * CHUNK;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

    state_t          state, state_nxt;
    logic [NPAD-1:0] a_ext, b_ext;
    logic [NPAD-1:0] a_q, b_q, c_q;
    logic            op_q;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            out_valid_q;
    logic            last_slice;
    logic [CHUNK-1:0] add_a, add_b, add_s;
    logic            add_op, add_cout;
`ifdef POS_ADDSUB_SEQ_ABS_EN
    logic            neg_q;
`endif

    // Operands are zero-padded to a whole number of slices; padding bits never reach c.
    for (genvar i = 0; i < NPAD; i++) begin : g_ext
        if (i < N_BITS_L && i < N_BITS_RESULT) begin : g_a
            assign a_ext[i] = a[i];
        end else begin : g_a0
            assign a_ext[i] = 1'b0;
        end
        if (i < N_BITS_R && i < N_BITS_RESULT) begin : g_b
            assign b_ext[i] = b[i];
        end else begin : g_b0
            assign b_ext[i] = 1'b0;
        end
    end

    if (N_BITS_L > N_BITS_RESULT) begin : g_unused_a
        logic unused_a;
        assign unused_a = ^a[N_BITS_L-1:N_BITS_RESULT];
    end
    if (N_BITS_R > N_BITS_RESULT) begin : g_unused_b
        logic unused_b;
        assign unused_b = ^b[N_BITS_R-1:N_BITS_RESULT];
    end
    if (NPAD > N_BITS_RESULT) begin : g_unused_c
        logic unused_c_pad;
        assign unused_c_pad = ^c_q[NPAD-1:N_BITS_RESULT];
    end

    assign last_slice = (cnt == CW'(NCH - 1));

    // NEG reuses the slice adder to form ~c + 1 with the carry preset to 1.
    always_comb begin
        add_a  = a_q[int'(cnt) * CHUNK +: CHUNK];
        add_b  = b_q[int'(cnt) * CHUNK +: CHUNK];
        add_op = op_q;
`ifdef POS_ADDSUB_SEQ_ABS_EN
        if (state == ST_NEG) begin
            add_a  = ~c_q[int'(cnt) * CHUNK +: CHUNK];
            add_b  = '0;
            add_op = OP_ADD;
        end
`endif
    end

    chunk_addsub #(.CHUNK(CHUNK)) u_chunk (
        .a    (add_a),
        .b    (add_b),
        .op   (add_op),
        .cin  (carry),
        .s    (add_s),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_RUN;
            ST_RUN: begin
                if (last_slice) begin
`ifdef POS_ADDSUB_SEQ_ABS_EN
                    if (op_q == OP_SUB && add_cout) state_nxt = ST_NEG;
                    else
`endif
                    state_nxt = ST_DONE;
                end
            end
`ifdef POS_ADDSUB_SEQ_ABS_EN
            ST_NEG: if (last_slice) state_nxt = ST_DONE;
`endif
            ST_DONE: if (out_valid_q && out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // out_valid is registered, so it rises one cycle after DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_SUB;
            c_q         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
`ifdef POS_ADDSUB_SEQ_ABS_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_ext;
                        b_q   <= b_ext;
                        op_q  <= op;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
`ifdef POS_ADDSUB_SEQ_ABS_EN
                ST_RUN, ST_NEG: begin
`else
                ST_RUN: begin
`endif
                    c_q[int'(cnt) * CHUNK +: CHUNK] <= add_s;
                    if (last_slice) begin
                        cnt <= '0;
`ifdef POS_ADDSUB_SEQ_ABS_EN
                        carry <= (state == ST_RUN) && (state_nxt == ST_NEG);
                        if (state == ST_RUN) neg_q <= (state_nxt == ST_NEG);
`else
                        carry <= 1'b0;
`endif
                    end else begin
                        cnt   <= cnt + 1'b1;
                        carry <= add_cout;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && out_ready) out_valid_q <= 1'b0;
                    else                          out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q[N_BITS_RESULT-1:0];
`ifdef POS_ADDSUB_SEQ_ABS_EN
    assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_pos_addsub_seq.sv
// tb/tb_pos_addsub_seq.sv - self-checking bench for pos_addsub_seq (honours POS_ADDSUB_SEQ_ABS_EN)
`timescale 1ns/1ps
module tb_pos_addsub_seq;

    localparam int NR = 9;
    localparam int ND = 4;
`ifdef POS_ADDSUB_SEQ_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op;
    logic [7:0]    a, b;
    logic          in_valid  [ND];
    logic          out_ready [ND];
    logic          in_ready  [ND];
    logic          out_valid [ND];
    logic [NR-1:0] c_o       [ND];
`ifdef POS_ADDSUB_SEQ_ABS_EN
    logic          neg_o     [ND];
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: 8x8 CHUNK=4, 1: 8x4 CHUNK=4, 2: CHUNK=1, 3: CHUNK=9
    pos_addsub_seq #(.N_BITS_L(8), .N_BITS_R(8), .N_BITS(0), .CHUNK(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op), .a(a), .b(b),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
`ifdef POS_ADDSUB_SEQ_ABS_EN
        .neg(neg_o[0]),
`endif
        .c(c_o[0]));
    pos_addsub_seq #(.N_BITS_L(8), .N_BITS_R(4), .N_BITS(0), .CHUNK(4)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op), .a(a), .b(b[3:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
`ifdef POS_ADDSUB_SEQ_ABS_EN
        .neg(neg_o[1]),
`endif
        .c(c_o[1]));
    pos_addsub_seq #(.N_BITS_L(8), .N_BITS_R(8), .N_BITS(0), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .op(op), .a(a), .b(b),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
`ifdef POS_ADDSUB_SEQ_ABS_EN
        .neg(neg_o[2]),
`endif
        .c(c_o[2]));
    pos_addsub_seq #(.N_BITS_L(8), .N_BITS_R(8), .N_BITS(0), .CHUNK(9)) u_cf (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .op(op), .a(a), .b(b),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]),
`ifdef POS_ADDSUB_SEQ_ABS_EN
        .neg(neg_o[3]),
`endif
        .c(c_o[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int chunk_of(input int k);
        case (k)
            2:       return 1;
            3:       return 9;
            default: return 4;
        endcase
    endfunction

    // Reference: plain integer arithmetic on the operands, result mod 2^9.
    task automatic model(input int k, input logic o, input logic [7:0] av, input logic [7:0] bv,
                         output logic [NR-1:0] ec, output logic en, output int el);
        int bb, r, n;
        bb = (k == 1) ? int'(bv[3:0]) : int'(bv);
        r  = o ? int'(av) + bb : int'(av) - bb;
        en = ABS && !o && (r < 0);
        if (en) r = -r;
        ec = NR'(r);
        n  = (NR + chunk_of(k) - 1) / chunk_of(k);
        el = n + 1 + (en ? n : 0);
    endtask

    task automatic run_op(input int k, input logic o, input logic [7:0] av, input logic [7:0] bv,
                          input string tag, input int stall);
        logic [NR-1:0] ec;
        logic          en;
        int            el, lat;
        model(k, o, av, bv, ec, en, el);
        check({tag, "_in_ready_idle"}, 32'(in_ready[k]), 1);
        in_valid[k] = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0; op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 0;
        while (!out_valid[k] && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, el);
        check({tag, "_c"}, 32'(c_o[k]), 32'(ec));
        check({tag, "_in_ready_busy"}, 32'(in_ready[k]), 0);
`ifdef POS_ADDSUB_SEQ_ABS_EN
        check({tag, "_neg"}, 32'(neg_o[k]), 32'(en));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid[k] = 1'b1; op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_c"}, 32'(c_o[k]), 32'(ec));
            check({tag, "_stall_out_valid"}, 32'(out_valid[k]), 1);
            check({tag, "_stall_in_ready"}, 32'(in_ready[k]), 0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        check({tag, "_out_valid_after"}, 32'(out_valid[k]), 0);
        check({tag, "_in_ready_after"}, 32'(in_ready[k]), 1);
        check({tag, "_c_retained"}, 32'(c_o[k]), 32'(ec));
    endtask

    initial begin
        for (int k = 0; k < ND; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            check("reset_in_ready", 32'(in_ready[k]), 1);
            check("reset_out_valid", 32'(out_valid[k]), 0);
            check("reset_c", 32'(c_o[k]), 0);
`ifdef POS_ADDSUB_SEQ_ABS_EN
            check("reset_neg", 32'(neg_o[k]), 0);
`endif
        end
        @(negedge clk);

        run_op(0, 1'b0, 8'd200, 8'd55, "sub_200_55", 0);
        run_op(0, 1'b0, 8'd5, 8'd10, "sub_5_10", 0);
        run_op(0, 1'b1, 8'd255, 8'd255, "add_255_255", 0);
        run_op(1, 1'b0, 8'h10, 8'h0F, "r4_sub", 0);
        run_op(1, 1'b1, 8'hFF, 8'hFF, "r4_add", 0);
        run_op(0, 1'b1, 8'd200, 8'd55, "stall", 5);

        // Reset during the second RUN cycle must abort without a result.
        in_valid[0] = 1'b1; op = 1'b0; a = 8'd200; b = 8'd55;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid[0]), 0);
        check("rst_c", 32'(c_o[0]), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready[0]), 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rst_no_output", 32'(out_valid[0]), 0);
        run_op(0, 1'b0, 8'd200, 8'd55, "after_rst", 0);

        run_op(2, 1'b0, 8'd0, 8'd255, "c1_edge", 0);
        run_op(3, 1'b0, 8'd0, 8'd255, "cf_edge", 0);
        run_op(3, 1'b1, 8'd255, 8'd255, "cf_max", 0);
        run_op(2, 1'b0, 8'd77, 8'd77, "c1_equal", 0);
        for (int i = 0; i < 10; i++) begin
            run_op(2, 1'($urandom), 8'($urandom), 8'($urandom), "c1_rand", 0);
            run_op(3, 1'($urandom), 8'($urandom), 8'($urandom), "cf_rand", 0);
            run_op(0, 1'($urandom), 8'($urandom), 8'($urandom), "main_rand", 0);
            run_op(1, 1'($urandom), 8'($urandom), 8'($urandom), "r4_rand", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
